// File: rtl/seq_log2_unit.sv
// seq_log2_unit: multi-cycle integer log2 (ceil or floor) of an unsigned operand.
// The operand is shifted right one bit per clock while a counter tracks the shifts;
// the bit length of the loaded value yields the result. Valid/ready on both sides.
module seq_log2_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CW    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_log,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_tmp;
    logic [CW-1:0]    r_count;
    logic             r_mode;
    logic             r_zero;
    logic [CW-1:0]    r_log;
    logic             r_out_zero;

    logic             w_accept;
    logic [WIDTH-1:0] w_load_tmp;
    logic [CW-1:0]    w_result;

    // Handshake decode; in_ready never looks at in_valid.
    always_comb begin
        in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
        w_accept  = in_valid && in_ready;
        out_valid = (r_state == StDone);
        out_log   = r_log;
        out_zero  = r_out_zero;
    end

    // Shift register load value; zero bypasses the ceil-mode decrement so it cannot wrap.
    always_comb begin
        w_load_tmp = '0;
        if (in_value != '0) begin
            w_load_tmp = in_mode ? in_value : (in_value - WIDTH'(1));
        end
    end

    // Final result from the shift count: ceil is the bit length of v-1, floor is bit length of v minus one.
    always_comb begin
        w_result = r_count;
        if (r_mode) begin
            w_result = r_zero ? '0 : (r_count - CW'(1));
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = StRun;
            end
            StRun: begin
                if (r_tmp == '0) w_state_next = StDone;
            end
            StDone: begin
                if (w_accept) begin
                    w_state_next = StRun;
                end else if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: load on accept, shift/count while running, latch result on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmp      <= '0;
            r_count    <= '0;
            r_mode     <= 1'b0;
            r_zero     <= 1'b0;
            r_log      <= '0;
            r_out_zero <= 1'b0;
        end else if (w_accept) begin
            r_tmp   <= w_load_tmp;
            r_count <= '0;
            r_mode  <= in_mode;
            r_zero  <= (in_value == '0);
        end else if (r_state == StRun) begin
            if (r_tmp != '0) begin
                r_tmp   <= r_tmp >> 1;
                r_count <= r_count + CW'(1);
            end else begin
                r_log      <= w_result;
                r_out_zero <= r_zero;
            end
        end
    end

endmodule

// File: tb/tb_seq_log2_unit.sv
// Directed self-checking bench for seq_log2_unit: a 64-bit instance with hand-computed
// vectors and a 5-bit instance swept exhaustively against a small reference model.
module tb_seq_log2_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 64-bit instance signals
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_zero;
    logic [63:0] in_value;
    logic [6:0]  out_log;

    // 5-bit instance signals
    logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_zero;
    logic [4:0]  s_in_value;
    logic [2:0]  s_out_log;

    int n_checks = 0;
    int n_pass   = 0;

    seq_log2_unit #(.WIDTH(64), .CW(7)) dut64 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_log  (out_log),
        .out_zero (out_zero)
    );

    seq_log2_unit #(.WIDTH(5), .CW(3)) dut5 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_value (s_in_value),
        .in_mode  (s_in_mode),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_log  (s_out_log),
        .out_zero (s_out_zero)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid on the 64-bit unit, counting edges since the accept edge.
    task automatic wait_result64(input string tag, input logic [6:0] exp_log,
                                 input logic exp_zero, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " log"}, 64'(out_log), 64'(exp_log));
        check_eq({tag, " zero"}, 64'(out_zero), 64'(exp_zero));
    endtask

    // Accept one operand (unit assumed idle), check result, let out_ready=1 consume it.
    task automatic op64(input string tag, input logic [63:0] v, input logic m,
                        input logic [6:0] exp_log, input logic exp_zero, input int exp_lat);
        in_value = v;
        in_mode  = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_value = '1;
        in_mode  = ~m;
        wait_result64(tag, exp_log, exp_zero, exp_lat);
        tick();
    endtask

    function automatic int ref_ceil(input int v);
        int r = 0;
        if (v <= 1) return 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ref_floor(input int v);
        int r = 0;
        if (v == 0) return 0;
        while ((2 << r) <= v) r++;
        return r;
    endfunction

    function automatic int bit_len(input int v);
        int n = 0;
        while (v != 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    initial begin
        logic [6:0] held_log;
        logic       held_zero;
        logic       stable;
        int         max_lat;
        int         lat;
        int         exp_log;
        int         exp_lat;
        int         seen;

        rst = 1'b1;
        in_valid = 1'b0; in_value = '0; in_mode = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_value = '0; s_in_mode = 1'b0; s_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset out_log", 64'(out_log), 64'd0);
        check_eq("reset out_zero", 64'(out_zero), 64'd0);
        check_eq("reset in_ready", 64'(in_ready), 64'd1);

        op64("ceil16", 64'd16, 1'b0, 7'd4, 1'b0, 5);
        op64("ceil17", 64'd17, 1'b0, 7'd5, 1'b0, 6);
        op64("floor17", 64'd17, 1'b1, 7'd4, 1'b0, 6);
        op64("floor1", 64'd1, 1'b1, 7'd0, 1'b0, 2);
        op64("ceil1", 64'd1, 1'b0, 7'd0, 1'b0, 1);
        op64("ceil0", 64'd0, 1'b0, 7'd0, 1'b1, 1);
        op64("floor0", 64'd0, 1'b1, 7'd0, 1'b1, 1);
        op64("ceilmax", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd64, 1'b0, 65);
        op64("floormax", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd63, 1'b0, 65);
        op64("floor2p40", 64'd1 << 40, 1'b1, 7'd40, 1'b0, 42);
        op64("ceil2p40", 64'd1 << 40, 1'b0, 7'd40, 1'b0, 41);

        // Back-pressure: hold the floor(17) result for 10 cycles.
        out_ready = 1'b0;
        in_value = 64'd17; in_mode = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result64("bp", 7'd4, 1'b0, 6);
        held_log = out_log;
        held_zero = out_zero;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_log !== held_log || out_zero !== held_zero || in_ready)
                stable = 1'b0;
        end
        check_eq("bp stable", 64'(stable), 64'd1);
        check_eq("bp in_ready low", 64'(in_ready), 64'd0);
        // Release with a new operand offered: accepted on the same edge.
        out_ready = 1'b1;
        in_value = 64'd8; in_mode = 1'b0; in_valid = 1'b1;
        #1;
        check_eq("b2b in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_eq("b2b no idle", 64'(out_valid), 64'd0);
        wait_result64("b2b ceil8", 7'd3, 1'b0, 4);
        tick();

        // Reset in the middle of a long floor computation.
        in_value = 64'd1 << 40; in_mode = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstrun out_valid", 64'(out_valid), 64'd0);
        check_eq("rstrun out_log", 64'(out_log), 64'd0);
        check_eq("rstrun out_zero", 64'(out_zero), 64'd0);
        check_eq("rstrun in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (60) begin
            tick();
            if (out_valid) seen++;
        end
        check_eq("rstrun no stale", 64'(seen), 64'd0);
        op64("post rst ceil16", 64'd16, 1'b0, 7'd4, 1'b0, 5);

        // 5-bit exhaustive sweep in both modes.
        max_lat = 0;
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 32; v++) begin
                exp_log = (m == 1) ? ref_floor(v) : ref_ceil(v);
                exp_lat = (v == 0) ? 1 : bit_len((m == 1) ? v : v - 1) + 1;
                s_in_value = 5'(v);
                s_in_mode = m[0];
                s_in_valid = 1'b1;
                tick();
                s_in_valid = 1'b0;
                lat = 0;
                while (!s_out_valid && lat < 50) begin
                    tick();
                    lat++;
                end
                if (lat > max_lat) max_lat = lat;
                check_eq($sformatf("w5 m%0d v%0d log", m, v), 64'(s_out_log), 64'(exp_log));
                check_eq($sformatf("w5 m%0d v%0d zero", m, v), 64'(s_out_zero),
                         64'(v == 0));
                check_eq($sformatf("w5 m%0d v%0d lat", m, v), 64'(lat), 64'(exp_lat));
                tick();
            end
        end
        check_eq("w5 max latency", 64'(max_lat), 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
